// File: rtl/io_buffer_loader.sv
// io_buffer_loader
//   Upstream feeder for the I/O line buffer. Packs WORDS_PER_LINE narrow host
//   words (valid/ready handshake) into one DATA_WIDTH-bit line and writes each
//   completed line to the buffer at an auto-incrementing, wrapping address.
//   One programmed burst of num_lines lines runs per start command.
//
//   Ports
//     clk, rst          clock / synchronous active-high reset
//     start             single-cycle burst start, honoured only when idle
//     base_addr         first line address (sampled on start)
//     num_lines         lines in burst (sampled on start), 0 = no-op burst
//     in_valid/in_ready/in_data   input word handshake
//     flush             (optional) terminate burst, writing a partial line
//     buf_write_enable, buf_addr, buf_data_in   buffer write port
//     busy              burst in progress
//     done              one-cycle pulse at burst end
//
//   Build option: define IO_BUFFER_LOADER_FLUSH_EN to add the flush input.
module io_buffer_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 256,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_lines,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
`ifdef IO_BUFFER_LOADER_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  buf_write_enable,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0] buf_data_in,
  output logic                  busy,
  output logic                  done
);

  localparam int WORDS_PER_LINE = DATA_WIDTH / WORD_WIDTH;
  localparam int LANE_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] cur_addr_reg;
  logic [ADDR_WIDTH:0]   lines_left_reg;
  logic [LANE_W-1:0]     lane_cnt_reg;
  logic [DATA_WIDTH-1:0] line_reg;
  logic                  in_ready_reg;
  logic                  buf_write_enable_reg;
  logic [ADDR_WIDTH-1:0] buf_addr_reg;
  logic [DATA_WIDTH-1:0] buf_data_in_reg;
  logic                  busy_reg;
  logic                  done_reg;
`ifdef IO_BUFFER_LOADER_FLUSH_EN
  logic                  term_reg;   // flush seen: burst ends after the pending write
`endif

  // in_ready_reg is only ever set in FILL, so a handshake implies FILL.
  logic                  hs;
  logic                  last_lane;
  logic [DATA_WIDTH-1:0] line_merged;
  logic                  fill_write;
  logic                  fill_done;
  logic                  last_line;

  assign hs        = in_valid & in_ready_reg;
  assign last_lane = (lane_cnt_reg == LANE_W'(WORDS_PER_LINE - 1));

  // Current line with the incoming word dropped into lane lane_cnt_reg.
  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_lane
      assign line_merged[gi*WORD_WIDTH +: WORD_WIDTH] =
        (lane_cnt_reg == LANE_W'(gi)) ? in_data : line_reg[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // FILL exit decisions. A flush with a word in the same cycle stores that
  // word first; a flush on an empty line ends the burst without a write.
  always_comb begin
    fill_write = hs & last_lane;
    fill_done  = 1'b0;
`ifdef IO_BUFFER_LOADER_FLUSH_EN
    if (flush) begin
      if (hs || lane_cnt_reg != '0) fill_write = 1'b1;
      else                          fill_done  = 1'b1;
    end
`endif
  end

`ifdef IO_BUFFER_LOADER_FLUSH_EN
  assign last_line = (lines_left_reg == (ADDR_WIDTH+1)'(1)) | term_reg;
`else
  assign last_line = (lines_left_reg == (ADDR_WIDTH+1)'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      cur_addr_reg         <= '0;
      lines_left_reg       <= '0;
      lane_cnt_reg         <= '0;
      line_reg             <= '0;
      in_ready_reg         <= 1'b0;
      buf_write_enable_reg <= 1'b0;
      buf_addr_reg         <= '0;
      buf_data_in_reg      <= '0;
      busy_reg             <= 1'b0;
      done_reg             <= 1'b0;
`ifdef IO_BUFFER_LOADER_FLUSH_EN
      term_reg             <= 1'b0;
`endif
    end else begin
      buf_write_enable_reg <= 1'b0;
      done_reg             <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            cur_addr_reg   <= base_addr;
            lines_left_reg <= num_lines;
            busy_reg       <= 1'b1;
            if (num_lines == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= FILL;
              in_ready_reg <= 1'b1;
            end
          end
        end
        FILL: begin
          if (hs) begin
            line_reg     <= line_merged;
            lane_cnt_reg <= lane_cnt_reg + LANE_W'(1);
          end
`ifdef IO_BUFFER_LOADER_FLUSH_EN
          if (flush) term_reg <= 1'b1;
`endif
          if (fill_write) begin
            state_reg            <= WRITE;
            in_ready_reg         <= 1'b0;
            buf_write_enable_reg <= 1'b1;
            buf_addr_reg         <= cur_addr_reg;
            buf_data_in_reg      <= hs ? line_merged : line_reg;
          end else if (fill_done) begin
            state_reg    <= DONE;
            in_ready_reg <= 1'b0;
            done_reg     <= 1'b1;
          end
        end
        WRITE: begin
          cur_addr_reg   <= cur_addr_reg + ADDR_WIDTH'(1);
          lines_left_reg <= lines_left_reg - (ADDR_WIDTH+1)'(1);
          line_reg       <= '0;
          lane_cnt_reg   <= '0;
          if (last_line) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
`ifdef IO_BUFFER_LOADER_FLUSH_EN
            term_reg  <= 1'b0;
`endif
          end else begin
            state_reg    <= FILL;
            in_ready_reg <= 1'b1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
`ifdef IO_BUFFER_LOADER_FLUSH_EN
          term_reg  <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready         = in_ready_reg;
  assign buf_write_enable = buf_write_enable_reg;
  assign buf_addr         = buf_addr_reg;
  assign buf_data_in      = buf_data_in_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;

endmodule
